// File: rtl/gcd_lcm_if.sv
// Request/response bundle for gcd_lcm_engine.
//   start/abort/mode/a_in/b_in : requester -> engine
//   busy/done/result/error     : engine -> requester
interface gcd_lcm_if #(
  parameter int unsigned WIDTH = 8
);
  logic               start;
  logic               abort;
  logic               mode;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               error;

  modport master (
    output start, abort, mode, a_in, b_in,
    input  busy, done, result, error
  );

  modport slave (
    input  start, abort, mode, a_in, b_in,
    output busy, done, result, error
  );
endinterface

// File: rtl/gcd_lcm_engine.sv
// Multi-cycle GCD / LCM engine.
//   GCD: binary (Stein) algorithm, one step per cycle.
//   LCM: (A / gcd) * B via a restoring divider then a shift-add multiplier.
// Ports: clk, rst_n (async active-low), bus (gcd_lcm_if.slave):
//   start/mode/a_in/b_in sampled in IDLE, abort cancels GCD/DIV/MUL,
//   busy/done/result/error are registered outputs.
module gcd_lcm_engine #(
  parameter int unsigned WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  gcd_lcm_if.slave  bus
);
  localparam int unsigned W  = WIDTH;
  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned KW = $clog2(WIDTH) + 1;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {IDLE, GCD, DIV, MUL, FIN} state_e;

  state_e          state_q, state_d;
  logic            mode_q, mode_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    x_q, x_d, y_q, y_d;
  logic [KW-1:0]   k_q, k_d;
  logic [W-1:0]    g_q, g_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    dvd_q, dvd_d;     // dividend, then quotient, then multiplier
  logic [RW-1:0]   mcand_q, mcand_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   result_q, result_d;
  logic            error_q, error_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [W-1:0]    g_w;
  logic [W:0]      rem_sh;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      k_q      <= '0;
      g_q      <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      x_q      <= x_d;
      y_q      <= y_d;
      k_q      <= k_d;
      g_q      <= g_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    a_d      = a_q;
    b_d      = b_q;
    x_d      = x_q;
    y_d      = y_q;
    k_d      = k_q;
    g_d      = g_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    error_d  = error_q;
    // gcd is never larger than the nonzero operand, so the shift cannot overflow
    g_w      = (x_q == '0) ? W'(y_q << k_q) : W'(x_q << k_q);
    rem_sh   = {rem_q, dvd_q[W-1]};

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d = bus.mode;
          a_d    = bus.a_in;
          b_d    = bus.b_in;
          x_d    = bus.a_in;
          y_d    = bus.b_in;
          k_d    = '0;
          if (bus.a_in == '0 && bus.b_in == '0) begin
            state_d  = FIN;
            result_d = '1;
            error_d  = 1'b1;
          end else begin
            state_d = GCD;
          end
        end
      end

      GCD: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (x_q == '0 || y_q == '0) begin
          if (!mode_q) begin
            state_d  = FIN;
            result_d = RW'(g_w);
            error_d  = 1'b0;
          end else if (a_q == '0 || b_q == '0) begin
            state_d  = FIN;
            result_d = '0;
            error_d  = 1'b0;
          end else begin
            state_d = DIV;
            g_d     = g_w;
            rem_d   = '0;
            dvd_d   = a_q;
            cnt_d   = '0;
          end
        end else if (!x_q[0] && !y_q[0]) begin
          x_d = x_q >> 1;
          y_d = y_q >> 1;
          k_d = k_q + KW'(1);
        end else if (!x_q[0]) begin
          x_d = x_q >> 1;
        end else if (!y_q[0]) begin
          y_d = y_q >> 1;
        end else if (x_q >= y_q) begin
          x_d = x_q - y_q;
        end else begin
          y_d = y_q - x_q;
        end
      end

      DIV: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          // Restoring step: quotient bits shift into the dividend register
          if (rem_sh >= {1'b0, g_q}) begin
            rem_d = W'(rem_sh - {1'b0, g_q});
            dvd_d = {dvd_q[W-2:0], 1'b1};
          end else begin
            rem_d = W'(rem_sh);
            dvd_d = {dvd_q[W-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) begin
            state_d = MUL;
            mcand_d = RW'(b_q);
            acc_d   = '0;
            cnt_d   = '0;
          end
        end
      end

      MUL: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          if (dvd_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d = mcand_q << 1;
          dvd_d   = dvd_q >> 1;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) begin
            state_d  = FIN;
            result_d = acc_d;
            error_d  = 1'b0;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == GCD) || (state_d == DIV) || (state_d == MUL);
    done_d = (state_d == FIN);
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.error  = error_q;

endmodule

// File: tb/tb_gcd_lcm_engine.sv
// Directed bench for gcd_lcm_engine (WIDTH=8) with an expected-result queue.
module tb_gcd_lcm_engine;
  localparam int unsigned W       = 8;
  localparam int          LAT_MAX = 8 * W + 8;

  typedef struct {
    logic [2*W-1:0] res;
    logic           err;
    int             lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  exp_t sb[$];

  gcd_lcm_if #(.WIDTH(W)) bus ();

  gcd_lcm_engine #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected result by Euclid; latency from counting Stein steps
  function automatic exp_t model(input bit m, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    int     x, y, s, ea, eb, t;
    longint lcm;
    if (a == 0 && b == 0) begin
      e.res = '1;
      e.err = 1'b1;
      e.lat = 1;
      return e;
    end
    x = int'(a); y = int'(b); s = 0;
    for (int i = 0; i < 200; i++) begin
      s++;
      if (x == 0 || y == 0) break;
      if (x % 2 == 0 && y % 2 == 0) begin x = x / 2; y = y / 2; end
      else if (x % 2 == 0) x = x / 2;
      else if (y % 2 == 0) y = y / 2;
      else if (x >= y) x = x - y;
      else y = y - x;
    end
    ea = int'(a); eb = int'(b);
    while (eb != 0) begin
      t = ea % eb; ea = eb; eb = t;
    end
    e.err = 1'b0;
    if (!m) begin
      e.res = (2*W)'(ea);
      e.lat = 1 + s;
    end else if (a == 0 || b == 0) begin
      e.res = '0;
      e.lat = 1 + s;
    end else begin
      lcm   = longint'(int'(a) / ea) * longint'(b);
      e.res = (2*W)'(lcm);
      e.lat = 1 + s + 2 * int'(W);
    end
    return e;
  endfunction

  task automatic run_op(input string tag, input bit m, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit poke, input bit ab);
    exp_t e;
    int   lat;
    bit   got;
    sb.push_back(model(m, a, b));
    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.a_in = a; bus.b_in = b; bus.abort = ab;
    lat = 0; got = 1'b0;
    while (!got && lat < LAT_MAX) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (poke && lat == 3) begin
        bus.start = 1'b1; bus.mode = ~m; bus.a_in = ~a; bus.b_in = W'(b + 1);
      end
      if (lat == 1 && !(a == 0 && b == 0)) chk({tag, "_busy"}, 64'(bus.busy), 64'(1));
      if (bus.done) got = 1'b1;
    end
    chk({tag, "_done"}, 64'(got), 64'(1));
    e = sb.pop_front();
    chk({tag, "_result"}, 64'(bus.result), 64'(e.res));
    chk({tag, "_error"}, 64'(bus.error), 64'(e.err));
    chk({tag, "_latency"}, 64'(lat), 64'(e.lat));
    chk({tag, "_busy_fin"}, 64'(bus.busy), 64'(0));
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_done_pulse"}, 64'(bus.done), 64'(0));
  endtask

  initial begin
    exp_t e;
    int   steps;
    int   dcnt;
    n_assert = 0; n_fail = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 1'b0; bus.a_in = '0; bus.b_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_result", 64'(bus.result), 64'(0));
    chk("rst_error", 64'(bus.error), 64'(0));
    rst_n = 1'b1;

    run_op("gcd_48_18", 1'b0, 8'd48, 8'd18, 1'b0, 1'b0);
    chk("gcd_48_18_bound", 64'(sb.size() == 0 && model(1'b0, 8'd48, 8'd18).lat <= 18), 64'(1));
    run_op("lcm_12_18", 1'b1, 8'd12, 8'd18, 1'b0, 1'b0);
    run_op("lcm_255_254", 1'b1, 8'd255, 8'd254, 1'b0, 1'b0);
    run_op("gcd_0_7", 1'b0, 8'd0, 8'd7, 1'b0, 1'b0);
    run_op("lcm_0_9", 1'b1, 8'd0, 8'd9, 1'b0, 1'b0);
    run_op("lcm_0_0", 1'b1, 8'd0, 8'd0, 1'b0, 1'b0);

    // Abort while dividing: outputs keep the 0/0 error result
    e = model(1'b1, 8'd200, 8'd150);
    steps = e.lat - 1 - 2 * int'(W);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 1'b1; bus.a_in = 8'd200; bus.b_in = 8'd150;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (steps + 2) @(negedge clk);
    chk("abort_busy_before", 64'(bus.busy), 64'(1));
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy_after", 64'(bus.busy), 64'(0));
    chk("abort_done", 64'(bus.done), 64'(0));
    chk("abort_result", 64'(bus.result), 64'(16'hFFFF));
    chk("abort_error", 64'(bus.error), 64'(1));
    dcnt = 0;
    repeat (3 * W) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("abort_no_done", 64'(dcnt), 64'(0));

    run_op("start_while_busy", 1'b0, 8'd48, 8'd18, 1'b1, 1'b0);
    run_op("abort_with_start", 1'b0, 8'd12, 8'd18, 1'b0, 1'b1);

    // Reset during multiply: outputs clear without a clock edge
    e = model(1'b1, 8'd12, 8'd18);
    steps = e.lat - 1 - 2 * int'(W);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 1'b1; bus.a_in = 8'd12; bus.b_in = 8'd18;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (steps + W + 2) @(negedge clk);
    chk("mul_busy", 64'(bus.busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mul_rst_busy", 64'(bus.busy), 64'(0));
    chk("mul_rst_done", 64'(bus.done), 64'(0));
    chk("mul_rst_result", 64'(bus.result), 64'(0));
    chk("mul_rst_error", 64'(bus.error), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (4 * W + 8) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("mul_rst_no_done", 64'(dcnt), 64'(0));

    // Start accepted on the first edge after reset release
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_op("after_reset", 1'b0, 8'd48, 8'd18, 1'b0, 1'b0);

    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
